// File: rtl/uart_rx_ram_if.sv
// uart_rx_ram_if
// Groups the receive-status and RAM read signals of uart_rx_ram into one
// bundle.
//   rx_dv    : one-clock pulse, a valid byte was received
//   rx_byte  : last valid received byte
//   wr_addr  : next RAM write address (count of stored bytes, wrapping)
//   rd_addr  : RAM read address, driven by the consumer
//   rd_data  : registered RAM read data (one clock after rd_addr)
// Modports: slave = the receiver/RAM block, master = the consumer of the data.
interface uart_rx_ram_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  rx_dv;
    logic [7:0]            rx_byte;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;

    modport slave (
        output rx_dv,
        output rx_byte,
        output wr_addr,
        output rd_data,
        input  rd_addr
    );

    modport master (
        input  rx_dv,
        input  rx_byte,
        input  wr_addr,
        input  rd_data,
        output rd_addr
    );
endinterface

// File: rtl/uart_rx_ram.sv
// uart_rx_ram
// 8N1 UART receiver (LSB first, idle high) whose valid bytes are written in
// arrival order into a 2^ADDR_WIDTH x 8 circular RAM with a separate
// registered read port.
// Parameters:
//   CLKS_PER_BIT : clocks per UART bit period (>= 4)
//   ADDR_WIDTH   : RAM address width
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rx_serial : UART line (asynchronous to clk)
//   bus       : slave side of uart_rx_ram_if (rx_dv, rx_byte, wr_addr,
//               rd_addr, rd_data)
module uart_rx_ram #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_serial,
    uart_rx_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // The start bit is re-checked near its middle so that all data samples
    // then land mid-bit, one full bit period apart.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset release never looks like a falling edge.
    // ------------------------------------------------------------------
    logic sync_meta_reg;
    logic rx_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b1;
            rx_sync_reg   <= 1'b1;
        end else begin
            sync_meta_reg <= rx_serial;
            rx_sync_reg   <= sync_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;
    logic             rx_dv_reg,   rx_dv_next;
    logic [7:0]       rx_byte_reg, rx_byte_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            rx_dv_reg   <= 1'b0;
            rx_byte_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            rx_dv_reg   <= rx_dv_next;
            rx_byte_reg <= rx_byte_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        rx_dv_next   = 1'b0;
        rx_byte_next = rx_byte_reg;

        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = '0;
                if (!rx_sync_reg) begin
                    state_next = START;
                end
            end

            START: begin
                if (clk_cnt_reg == START_LAST) begin
                    clk_cnt_next = '0;
                    // Line back high by mid start bit: treat as a glitch.
                    state_next   = rx_sync_reg ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next             = '0;
                    shift_next[bit_idx_reg]  = rx_sync_reg;
                    bit_idx_next             = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = CLEANUP;
                    // A low stop bit is a framing error: the byte is dropped.
                    if (rx_sync_reg) begin
                        rx_dv_next   = 1'b1;
                        rx_byte_next = shift_reg;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            CLEANUP: begin
                clk_cnt_next = '0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Circular RAM. Contents are deliberately not reset; only the write
    // pointer and the read register are.
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [7:0]            rd_data_reg;

    always_ff @(posedge clk) begin
        if (rx_dv_reg) begin
            mem[wr_addr_reg] <= rx_byte_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= '0;
        end else if (rx_dv_reg) begin
            wr_addr_reg <= wr_addr_reg + 1'b1;
        end
    end

    // Read-before-write: a read at the address written on the same edge
    // returns the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[bus.rd_addr];
        end
    end

    assign bus.rx_dv   = rx_dv_reg;
    assign bus.rx_byte = rx_byte_reg;
    assign bus.wr_addr = wr_addr_reg;
    assign bus.rd_data = rd_data_reg;

endmodule

// File: tb/tb_uart_rx_ram.sv
// tb_uart_rx_ram
// Directed and randomized frames into two instances: dut_a at 87 clk/bit for
// the functional cases, dut_b at 8 clk/bit for the address-wrap case. The
// expected RAM image and write pointer come from a plain array model.
module tb_uart_rx_ram;
    localparam int CPB_A = 87;
    localparam int CPB_B = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_a;
    logic rx_b;

    always #5 clk = ~clk;

    uart_rx_ram_if #(.ADDR_WIDTH(AW)) bus_a ();
    uart_rx_ram_if #(.ADDR_WIDTH(AW)) bus_b ();

    uart_rx_ram #(.CLKS_PER_BIT(CPB_A), .ADDR_WIDTH(AW)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_a),
        .bus       (bus_a)
    );

    uart_rx_ram #(.CLKS_PER_BIT(CPB_B), .ADDR_WIDTH(AW)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_b),
        .bus       (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- rx_dv monitors ----------------
    logic [7:0] dv_q_a[$];
    int         dv_cnt_b = 0;
    int         wide_a   = 0;
    int         wide_b   = 0;
    logic       prev_a   = 1'b0;
    logic       prev_b   = 1'b0;

    always @(negedge clk) begin
        if (bus_a.rx_dv === 1'b1) begin
            dv_q_a.push_back(bus_a.rx_byte);
            if (prev_a) wide_a++;
        end
        if (bus_b.rx_dv === 1'b1) begin
            dv_cnt_b++;
            if (prev_b) wide_b++;
        end
        prev_a = (bus_a.rx_dv === 1'b1);
        prev_b = (bus_b.rx_dv === 1'b1);
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [DEPTH];
    int         ref_wr = 0;

    function automatic void model_store(input logic [7:0] b);
        ref_mem[ref_wr % DEPTH] = b;
        ref_wr++;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_level(input bit which, input logic lvl, input int n);
        if (which) rx_b = lvl;
        else       rx_a = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input bit which, input logic [7:0] b, input int cpb);
        drive_level(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_level(which, b[i], cpb);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] b, input int cpb);
        drive_bits(which, b, cpb);
        drive_level(which, 1'b1, cpb);
    endtask

    task automatic read_mem(input bit which, input int addr, output logic [7:0] d);
        if (which) bus_b.rd_addr = AW'(addr);
        else       bus_a.rd_addr = AW'(addr);
        @(negedge clk);
        d = which ? bus_b.rd_data : bus_a.rd_data;
    endtask

    // One valid frame on dut_a just completed: exactly one pulse carrying b.
    task automatic expect_rx(input string tag, input logic [7:0] b);
        check({tag, "_dv_count"}, dv_q_a.size(), 1);
        if (dv_q_a.size() > 0) check({tag, "_dv_byte"}, dv_q_a.pop_front(), b);
        dv_q_a.delete();
        check({tag, "_rx_byte"}, bus_a.rx_byte, b);
        model_store(b);
        check({tag, "_wr_addr"}, bus_a.wr_addr, ref_wr % DEPTH);
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_no_dv"}, dv_q_a.size(), 0);
        dv_q_a.delete();
        check({tag, "_wr_addr"}, bus_a.wr_addr, ref_wr % DEPTH);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #6_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] c3;
        logic [7:0] last_byte;
        logic [7:0] old;
        bit         seen;
        int         n_rand;

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        bus_a.rd_addr = '0;
        bus_b.rd_addr = '0;
        repeat (4) @(negedge clk);

        check("rst_rx_dv",   bus_a.rx_dv,   0);
        check("rst_rx_byte", bus_a.rx_byte, 8'h00);
        check("rst_wr_addr", bus_a.wr_addr, 0);
        check("rst_rd_data", bus_a.rd_data, 8'h00);

        rst_n = 1'b1;
        drive_level(0, 1'b1, 20);

        // Back-to-back 0x0F, 0xAA, 0x80
        send_frame(0, 8'h0F, CPB_A); expect_rx("b2b0", 8'h0F);
        send_frame(0, 8'hAA, CPB_A); expect_rx("b2b1", 8'hAA);
        send_frame(0, 8'h80, CPB_A); expect_rx("b2b2", 8'h80);
        drive_level(0, 1'b1, 10);
        read_mem(0, 0, d); check("b2b_rd0", d, 8'h0F);
        read_mem(0, 1, d); check("b2b_rd1", d, 8'hAA);
        read_mem(0, 2, d); check("b2b_rd2", d, 8'h80);
        last_byte = 8'h80;

        // 20-clock glitch must be rejected; a following frame still works.
        drive_level(0, 1'b0, 20);
        drive_level(0, 1'b1, 3 * CPB_A);
        expect_none("glitch");
        check("glitch_rx_byte", bus_a.rx_byte, last_byte);

        // 0x55 with a low stop bit, then a valid 0x33.
        drive_bits(0, 8'h55, CPB_A);
        drive_level(0, 1'b0, (2 * CPB_A) / 3);
        drive_level(0, 1'b1, 3 * CPB_A);
        expect_none("framing");
        check("framing_rx_byte", bus_a.rx_byte, last_byte);
        send_frame(0, 8'h33, CPB_A); expect_rx("after_framing", 8'h33);

        // Random bytes, then read back the whole written region.
        n_rand = 8;
        for (int i = 0; i < n_rand; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(0, b, CPB_A);
            expect_rx($sformatf("rand%0d", i), b);
        end
        drive_level(0, 1'b1, 4);
        for (int a = 0; a < ref_wr; a++) begin
            read_mem(0, a, d);
            check($sformatf("rand_rd%0d", a), d, ref_mem[a]);
        end

        // Reset during DATA of 0xC3: nothing stored; RAM survives reset.
        c3 = 8'hC3;
        dv_q_a.delete();
        drive_level(0, 1'b0, CPB_A);
        for (int i = 0; i < 3; i++) drive_level(0, c3[i], CPB_A);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_rx_dv",   bus_a.rx_dv,   0);
        check("midrst_wr_addr", bus_a.wr_addr, 0);
        check("midrst_rx_byte", bus_a.rx_byte, 8'h00);
        check("midrst_rd_data", bus_a.rd_data, 8'h00);
        rst_n = 1'b1;
        drive_level(0, 1'b1, 3 * CPB_A);
        check("midrst_no_dv", dv_q_a.size(), 0);
        ref_wr = 0;
        send_frame(0, 8'h5A, CPB_A); expect_rx("after_rst", 8'h5A);
        drive_level(0, 1'b1, 4);
        read_mem(0, 0, d); check("after_rst_rd0", d, 8'h5A);
        read_mem(0, 1, d); check("ram_kept_rd1", d, ref_mem[1]);

        // Read at the address being written in the rx_dv cycle.
        old = ref_mem[ref_wr % DEPTH];
        bus_a.rd_addr = AW'(ref_wr % DEPTH);
        drive_bits(0, 8'h77, CPB_A);
        rx_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * CPB_A && !seen; i++) begin
            @(negedge clk);
            if (bus_a.rx_dv === 1'b1) seen = 1'b1;
        end
        check("rw_dv_seen", seen, 1);
        @(negedge clk);
        check("rw_old_data", bus_a.rd_data, old);
        @(negedge clk);
        check("rw_new_data", bus_a.rd_data, 8'h77);
        drive_level(0, 1'b1, CPB_A);
        expect_rx("rw", 8'h77);

        // Address wrap on dut_b: 513 bytes of value index mod 256.
        for (int i = 0; i < 513; i++) send_frame(1, 8'(i), CPB_B);
        drive_level(1, 1'b1, 4 * CPB_B);
        check("wrap_dv_count", dv_cnt_b, 513);
        check("wrap_wr_addr",  bus_b.wr_addr, 1);
        read_mem(1, 0,   d); check("wrap_rd0",   d, 8'h00);
        read_mem(1, 1,   d); check("wrap_rd1",   d, 8'h01);
        read_mem(1, 256, d); check("wrap_rd256", d, 8'h00);
        read_mem(1, 511, d); check("wrap_rd511", d, 8'hFF);
        send_frame(1, 8'hE7, CPB_B);
        drive_level(1, 1'b1, 4 * CPB_B);
        check("wrap2_wr_addr", bus_b.wr_addr, 2);
        read_mem(1, 1, d); check("wrap2_rd1", d, 8'hE7);
        read_mem(1, 2, d); check("wrap2_rd2", d, 8'h02);

        check("dv_width_a", wide_a, 0);
        check("dv_width_b", wide_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
